// File: rtl/tag_match_encoder.sv
// ============================================================================
// Module  : tag_match_encoder
// Brief   : 4-line fully-associative tag store with a registered parallel
//           compare and a lowest-index priority encoder for the data cache.
//           Optional macro TAG_MATCH_MULTIHIT_CHECK_EN enables multi_hit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_match_encoder #(
  parameter int TAG_WIDTH = 28,
  parameter int NUM_LINES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lookup_en,
  input  logic [TAG_WIDTH-1:0] lookup_tag,
  input  logic                 wr_en,
  input  logic [1:0]           wr_line,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic                 inv_en,
  input  logic [1:0]           inv_line,
  output logic                 result_valid,
  output logic                 hit,
  output logic [NUM_LINES-1:0] hit_vector,
  output logic [1:0]           line_number,
  output logic [NUM_LINES-1:0] valid_bits,
  output logic                 multi_hit
);

  localparam int IDX_W = 2;

  logic [TAG_WIDTH-1:0] tag_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] match;
  logic [IDX_W-1:0]     enc_line;

  // Per-line storage; invalidate has priority over install on the valid bit,
  // while the tag itself is still written.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
      logic wr_sel;
      logic inv_sel;

      assign wr_sel  = wr_en  && (wr_line  == IDX_W'(gi));
      assign inv_sel = inv_en && (inv_line == IDX_W'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tag_q[gi] <= '0;
        end else if (wr_sel) begin
          tag_q[gi] <= wr_tag;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q[gi] <= 1'b0;
        end else if (inv_sel) begin
          valid_q[gi] <= 1'b0;
        end else if (wr_sel) begin
          valid_q[gi] <= 1'b1;
        end
      end

      assign match[gi] = valid_q[gi] && (tag_q[gi] == lookup_tag);
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the last to win.
  always_comb begin
    enc_line = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (match[i]) begin
        enc_line = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid <= 1'b0;
      hit          <= 1'b0;
      hit_vector   <= '0;
      line_number  <= '0;
    end else if (lookup_en) begin
      result_valid <= 1'b1;
      hit          <= |match;
      hit_vector   <= match;
      line_number  <= enc_line;
    end else begin
      result_valid <= 1'b0;
    end
  end

`ifdef TAG_MATCH_MULTIHIT_CHECK_EN
  logic multi_next;

  // Clearing the lowest set bit leaves a nonzero value only if two or more bits were set.
  assign multi_next = |(match & (match - NUM_LINES'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      multi_hit <= 1'b0;
    end else if (lookup_en) begin
      multi_hit <= multi_next;
    end else begin
      multi_hit <= 1'b0;
    end
  end
`else
  assign multi_hit = 1'b0;
`endif

  assign valid_bits = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_tag_match_encoder.sv
// Directed bench for tag_match_encoder: a behavioural tag/valid model feeds
// an expected-result queue that is popped when each registered result appears.
`default_nettype none

module tb_tag_match_encoder;

  localparam int TW = 28;

  logic          clk = 1'b0;
  logic          reset;
  logic          lookup_en;
  logic [TW-1:0] lookup_tag;
  logic          wr_en;
  logic [1:0]    wr_line;
  logic [TW-1:0] wr_tag;
  logic          inv_en;
  logic [1:0]    inv_line;
  logic          result_valid;
  logic          hit;
  logic [3:0]    hit_vector;
  logic [1:0]    line_number;
  logic [3:0]    valid_bits;
  logic          multi_hit;

  tag_match_encoder #(.TAG_WIDTH(TW), .NUM_LINES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_en    (lookup_en),
    .lookup_tag   (lookup_tag),
    .wr_en        (wr_en),
    .wr_line      (wr_line),
    .wr_tag       (wr_tag),
    .inv_en       (inv_en),
    .inv_line     (inv_line),
    .result_valid (result_valid),
    .hit          (hit),
    .hit_vector   (hit_vector),
    .line_number  (line_number),
    .valid_bits   (valid_bits),
    .multi_hit    (multi_hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic [3:0] hv;
    logic [1:0] ln;
    logic       mh;
  } exp_t;

  exp_t    sb[$];
  exp_t    held;
  logic [TW-1:0] m_tag [4];
  logic [3:0]    m_valid;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [TW-1:0] t);
    exp_t e;
    int   cnt;
    e   = '0;
    cnt = 0;
    for (int i = 3; i >= 0; i--) begin
      if (m_valid[i] && m_tag[i] == t) begin
        e.hv[i] = 1'b1;
        e.ln    = 2'(i);
        cnt++;
      end
    end
    e.hit = (cnt > 0);
`ifdef TAG_MATCH_MULTIHIT_CHECK_EN
    e.mh = (cnt > 1);
`else
    e.mh = 1'b0;
`endif
    return e;
  endfunction

  task automatic model_clear();
    m_valid = '0;
    for (int i = 0; i < 4; i++) m_tag[i] = '0;
  endtask

  // One clock of stimulus followed by checking the registered outputs.
  task automatic cycle(input string name,
                       input logic lk, input logic [TW-1:0] lt,
                       input logic we, input logic [1:0] wl, input logic [TW-1:0] wt,
                       input logic ie, input logic [1:0] il);
    exp_t e;
    @(negedge clk);
    lookup_en = lk; lookup_tag = lt;
    wr_en = we; wr_line = wl; wr_tag = wt;
    inv_en = ie; inv_line = il;
    if (lk) sb.push_back(predict(lt));
    if (we) begin m_tag[wl] = wt; m_valid[wl] = 1'b1; end
    if (ie) m_valid[il] = 1'b0;
    @(posedge clk);
    #1;
    if (lk) begin
      e    = sb.pop_front();
      held = e;
      chk({name, ".result_valid"}, 32'(result_valid), 32'd1);
      chk({name, ".multi_hit"},    32'(multi_hit),    32'(e.mh));
    end else begin
      chk({name, ".result_valid"}, 32'(result_valid), 32'd0);
      chk({name, ".multi_hit"},    32'(multi_hit),    32'd0);
    end
    chk({name, ".hit"},         32'(hit),         32'(held.hit));
    chk({name, ".hit_vector"},  32'(hit_vector),  32'(held.hv));
    chk({name, ".line_number"}, 32'(line_number), 32'(held.ln));
    chk({name, ".valid_bits"},  32'(valid_bits),  32'(m_valid));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".result_valid"}, 32'(result_valid), 32'd0);
    chk({name, ".hit"},          32'(hit),          32'd0);
    chk({name, ".hit_vector"},   32'(hit_vector),   32'd0);
    chk({name, ".line_number"},  32'(line_number),  32'd0);
    chk({name, ".valid_bits"},   32'(valid_bits),   32'd0);
    chk({name, ".multi_hit"},    32'(multi_hit),    32'd0);
  endtask

  initial begin
    reset = 1'b1;
    lookup_en = 0; lookup_tag = '0; wr_en = 0; wr_line = 0; wr_tag = '0;
    inv_en = 0; inv_line = 0;
    held = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    cycle("lk_empty",   1, 28'h0000ABC, 0, 2'd0, '0, 0, 2'd0);
    cycle("wr_l2",      0, '0,          1, 2'd2, 28'h0000ABC, 0, 2'd0);
    cycle("lk_l2",      1, 28'h0000ABC, 0, 2'd0, '0, 0, 2'd0);
    cycle("wr_l1",      0, '0,          1, 2'd1, 28'h1234567, 0, 2'd0);
    cycle("wr_l3",      0, '0,          1, 2'd3, 28'h1234567, 0, 2'd0);
    cycle("lk_multi",   1, 28'h1234567, 0, 2'd0, '0, 0, 2'd0);
    cycle("idle_hold",  0, 28'h1234567, 0, 2'd0, '0, 0, 2'd0);
    cycle("wr_lk_same", 1, 28'h0000055, 1, 2'd0, 28'h0000055, 0, 2'd0);
    cycle("lk_l0",      1, 28'h0000055, 0, 2'd0, '0, 0, 2'd0);
    cycle("inv_wr_l2",  0, '0,          1, 2'd2, 28'h0000ABC, 1, 2'd2);
    cycle("lk_inv_l2",  1, 28'h0000ABC, 0, 2'd0, '0, 0, 2'd0);
    cycle("wr2_inv0",   0, '0,          1, 2'd2, 28'h0000077, 1, 2'd0);
    cycle("lk_77",      1, 28'h0000077, 0, 2'd0, '0, 0, 2'd0);
    cycle("lk_55_gone", 1, 28'h0000055, 0, 2'd0, '0, 0, 2'd0);
    cycle("wr_l0_dup",  0, '0,          1, 2'd0, 28'h1234567, 0, 2'd0);
    cycle("lk_prio",    1, 28'h1234567, 0, 2'd0, '0, 0, 2'd0);
    cycle("lk_l2_hit",  1, 28'h0000077, 0, 2'd0, '0, 0, 2'd0);

    // Asynchronous reset between edges clears outputs without a clock edge.
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    lookup_en = 1'b1; lookup_tag = 28'h0000077;
    @(posedge clk);
    #1;
    chk_all_zero("lk_in_rst");
    @(negedge clk);
    lookup_en = 1'b0;
    reset = 1'b0;
    model_clear();
    held = '0;

    cycle("lk_after_rst0", 1, 28'h0000000, 0, 2'd0, '0, 0, 2'd0);
    cycle("lk_after_rst1", 1, 28'h0000077, 0, 2'd0, '0, 0, 2'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
